// File: rtl/vx_mem_responder_if.sv
// Vortex external memory request/response bundle.
// The core drives requests through the master modport; the memory-side responder
// answers through the slave modport.
interface vx_mem_responder_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 7
);
  localparam int BYTEEN_WIDTH = DATA_WIDTH / 8;

  logic                    mem_req_valid;
  logic                    mem_req_rw;
  logic [BYTEEN_WIDTH-1:0] mem_req_byteen;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic [DATA_WIDTH-1:0]   mem_req_data;
  logic [TAG_WIDTH-1:0]    mem_req_tag;
  logic                    mem_req_ready;

  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rsp_data;
  logic [TAG_WIDTH-1:0]    mem_rsp_tag;
  logic                    mem_rsp_ready;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/vx_mem_responder.sv
// Memory-side responder for the Vortex mem_req/mem_rsp interface.
// It holds a byte-enabled line store. Reads travel through a fixed-latency delay line
// into an in-order response FIFO. Request acceptance is throttled by the outstanding-read
// count, so the FIFO can never overflow.
module vx_mem_responder #(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = 7,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE      = 8
) (
  input  logic              clk,
  input  logic              reset,
  vx_mem_responder_if.slave mem_if,
  output logic              busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int PW    = $clog2(RSP_QUEUE);
  localparam int CW    = PW + 1;

  // Backing store and request decode
  logic [DATA_WIDTH-1:0]     store [DEPTH];
  logic [MEM_DEPTH_LOG2-1:0] line;
  logic                      req_fire;
  logic                      rd_fire;
  logic                      wr_fire;

  // Outstanding reads: delay line plus FIFO
  logic [CW-1:0]             outstanding;

  // Fixed-latency delay line
  logic [LATENCY-1:0]        pipe_valid;
  logic [DATA_WIDTH-1:0]     pipe_data [LATENCY];
  logic [TAG_WIDTH-1:0]      pipe_tag  [LATENCY];

  // Response FIFO; pointers carry one extra wrap bit
  logic [DATA_WIDTH-1:0]     fifo_data [RSP_QUEUE];
  logic [TAG_WIDTH-1:0]      fifo_tag  [RSP_QUEUE];
  logic [PW:0]               wr_ptr;
  logic [PW:0]               rd_ptr;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      push;
  logic                      pop;

  assign line     = mem_if.mem_req_addr[MEM_DEPTH_LOG2-1:0];
  assign mem_if.mem_req_ready = !reset && (outstanding < CW'(RSP_QUEUE));
  assign req_fire = mem_if.mem_req_valid && mem_if.mem_req_ready;
  assign rd_fire  = req_fire && !mem_if.mem_req_rw;
  assign wr_fire  = req_fire &&  mem_if.mem_req_rw;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push       = pipe_valid[LATENCY-1] && !fifo_full;
  assign pop        = !fifo_empty && mem_if.mem_rsp_ready;

  assign mem_if.mem_rsp_valid = !fifo_empty;
  assign mem_if.mem_rsp_data  = fifo_empty ? '0 : fifo_data[rd_ptr[PW-1:0]];
  assign mem_if.mem_rsp_tag   = fifo_empty ? '0 : fifo_tag[rd_ptr[PW-1:0]];
  assign busy                 = (outstanding != '0);

  // Byte-enabled line write. A read in the next cycle sees the update.
  // NOTE: storage arrays have no reset, so they map onto RAM and keep their contents across reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < BYTES; i++) begin
        if (mem_if.mem_req_byteen[i]) begin
          store[line][i*8 +: 8] <= mem_if.mem_req_data[i*8 +: 8];
        end
      end
    end
  end

  // Delay-line valid bits: only these need clearing on reset.
  // NOTE: every clocked block uses non-blocking assignments, so stage-to-stage shifts read the old values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= rd_fire;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // Delay-line payload: the line is read at the accepting edge, then shifted along.
  always_ff @(posedge clk) begin
    pipe_data[0] <= store[line];
    pipe_tag[0]  <= mem_if.mem_req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
      pipe_tag[i]  <= pipe_tag[i-1];
    end
  end

  // FIFO payload write at the tail
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr[PW-1:0]] <= pipe_data[LATENCY-1];
      fifo_tag[wr_ptr[PW-1:0]]  <= pipe_tag[LATENCY-1];
    end
  end

  // FIFO pointers. The head holds still until the response handshake completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Outstanding-read counter. A simultaneous accept and consume leaves it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else if (rd_fire && !pop) begin
      outstanding <= outstanding + 1'b1;
    end else if (!rd_fire && pop) begin
      outstanding <= outstanding - 1'b1;
    end
  end

endmodule

// File: tb/tb_vx_mem_responder.sv
// Bench for vx_mem_responder.
// A queue-based reference model predicts which read data and tag are due on each cycle.
// Directed sequences cover write/read, byte enables, back-pressure, write-only traffic,
// address aliasing and reset in the middle of operation.
module tb_vx_mem_responder;

  localparam int LAT   = 4;
  localparam int QUEUE = 8;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [511:0] data;
    logic [6:0]   tag;
    longint       due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  int checks = 0;
  int errors = 0;
  int rsp_seen = 0;
  longint cyc = 0;

  exp_t         exp_q[$];
  logic [6:0]   got_tags[$];
  logic [511:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  vx_mem_responder_if #(.DATA_WIDTH(512), .ADDR_WIDTH(26), .TAG_WIDTH(7)) mif ();

  vx_mem_responder dut (
    .clk    (clk),
    .reset  (reset),
    .mem_if (mif),
    .busy   (busy)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model and compare. At each falling edge, compare against the state left by the
  // last rising edge. Then step the model using the inputs the next rising edge will sample.
  always @(negedge clk) begin : model
    logic ev;
    logic fire;
    int   ln;
    exp_t e;
    if (reset) begin
      exp_q.delete();
      check("rst_rsp_valid", mif.mem_rsp_valid, 0);
      check("rst_rsp_data", mif.mem_rsp_data, 0);
      check("rst_rsp_tag", mif.mem_rsp_tag, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", mif.mem_req_ready, 0);
    end else begin
      ev = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      check("rsp_valid", mif.mem_rsp_valid, ev);
      check("req_ready", mif.mem_req_ready, exp_q.size() < QUEUE);
      check("busy", busy, exp_q.size() != 0);
      if (ev) begin
        check("rsp_data", mif.mem_rsp_data, exp_q[0].data);
        check("rsp_tag", mif.mem_rsp_tag, exp_q[0].tag);
      end
      if (mif.mem_rsp_valid) rsp_seen++;
      if (mif.mem_rsp_valid && mif.mem_rsp_ready) got_tags.push_back(mif.mem_rsp_tag);

      fire = mif.mem_req_valid && (exp_q.size() < QUEUE);
      cyc++;
      if (ev && mif.mem_rsp_ready) void'(exp_q.pop_front());
      if (fire) begin
        ln = int'(mif.mem_req_addr) % DEPTH;
        if (mif.mem_req_rw) begin
          for (int i = 0; i < 64; i++)
            if (mif.mem_req_byteen[i]) ref_mem[ln][i*8 +: 8] = mif.mem_req_data[i*8 +: 8];
        end else begin
          e.data = ref_mem[ln];
          e.tag  = mif.mem_req_tag;
          e.due  = cyc + LAT;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Issue one request and hold it until accepted. Starts and ends 1 time unit after a rising edge.
  task automatic send(input logic rw, input logic [25:0] addr, input logic [63:0] be,
                      input logic [511:0] d, input logic [6:0] tag);
    bit acc = 0;
    mif.mem_req_valid  = 1'b1;
    mif.mem_req_rw     = rw;
    mif.mem_req_addr   = addr;
    mif.mem_req_byteen = be;
    mif.mem_req_data   = d;
    mif.mem_req_tag    = tag;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      acc = mif.mem_req_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) check("req_timeout", mif.mem_req_ready, 1);
    mif.mem_req_valid = 1'b0;
  endtask

  // Wait for the next response. lat counts the full cycles from the call until rsp_valid is seen.
  task automatic get_rsp(output logic [511:0] d, output logic [6:0] t, output int lat);
    bit got = 0;
    d = '0; t = '0; lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (mif.mem_rsp_valid) begin
        d = mif.mem_rsp_data; t = mif.mem_rsp_tag; lat = k - 1; got = 1;
        break;
      end
    end
    if (!got) check("rsp_timeout", mif.mem_rsp_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy && !mif.mem_rsp_valid) begin ok = 1; break; end
    end
    if (!ok) check("idle_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [511:0] d;
    logic [511:0] e2;
    logic [6:0]   t;
    int           lat;
    int           acc;
    int           nxt;
    int           seen;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    mif.mem_req_valid = 1'b0; mif.mem_req_rw = 1'b0; mif.mem_req_byteen = '0;
    mif.mem_req_addr = '0; mif.mem_req_data = '0; mif.mem_req_tag = '0;
    mif.mem_rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("hold_reset_ready", mif.mem_req_ready, 0);
    reset = 1'b0;
    #1;
    check("release_ready", mif.mem_req_ready, 1);
    check("release_busy", busy, 0);
    @(posedge clk); #1;

    // Test 1: write, then read on the next cycle; check latency, data and tag
    send(1'b1, 26'h10, '1, {16{32'hDEADBEEF}}, 7'h0);
    send(1'b0, 26'h10, '0, '0, 7'h15);
    get_rsp(d, t, lat);
    check("t1_latency", 32'(lat), 4);
    check("t1_data", d, {16{32'hDEADBEEF}});
    check("t1_tag", t, 7'h15);
    wait_idle();

    // Test 2: partial byte-enable overwrite
    send(1'b1, 26'h20, '1, '1, 7'h0);
    send(1'b1, 26'h20, 64'h1, 512'hAB, 7'h0);
    send(1'b0, 26'h20, '0, '0, 7'h22);
    get_rsp(d, t, lat);
    e2 = {{63{8'hFF}}, 8'hAB};
    check("t2_data", d, e2);
    check("t2_tag", t, 7'h22);
    wait_idle();

    // Test 3: back-pressure fills the response queue
    for (int i = 0; i < 10; i++) send(1'b1, 26'h100 + 26'(i), '1, {16{32'h1000_0000 + i}}, 7'h0);
    got_tags.delete();
    mif.mem_rsp_ready = 1'b0;
    acc = 0; nxt = 0;
    for (int c = 0; c < 12; c++) begin
      mif.mem_req_valid = (nxt < 10);
      mif.mem_req_rw    = 1'b0;
      mif.mem_req_addr  = 26'h100 + 26'(nxt);
      mif.mem_req_tag   = 7'(nxt);
      @(negedge clk);
      if (mif.mem_req_valid && mif.mem_req_ready) begin acc++; nxt++; end
      @(posedge clk); #1;
    end
    mif.mem_req_valid = 1'b0;
    check("t3_accepted", 32'(acc), 8);
    check("t3_ready_low", mif.mem_req_ready, 0);
    check("t3_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    mif.mem_rsp_ready = 1'b1;
    while (nxt < 10) begin
      send(1'b0, 26'h100 + 26'(nxt), '0, '0, 7'(nxt));
      nxt++;
    end
    wait_idle();
    check("t3_rsp_count", 32'(got_tags.size()), 10);
    for (int i = 0; i < 10 && i < got_tags.size(); i++) check($sformatf("t3_order%0d", i), got_tags[i], 7'(i));

    // Test 4: writes never generate responses
    seen = rsp_seen;
    send(1'b1, 26'h30, '1, 512'h30, 7'h1);
    send(1'b1, 26'h31, '1, 512'h31, 7'h2);
    send(1'b1, 26'h32, '1, 512'h32, 7'h3);
    @(negedge clk);
    check("t4_no_rsp", 32'(rsp_seen), 32'(seen));
    check("t4_busy", busy, 0);
    check("t4_ready", mif.mem_req_ready, 1);
    @(posedge clk); #1;

    // Test 5: upper address bits alias
    send(1'b1, 26'h400, '1, 512'h1234, 7'h0);
    send(1'b0, 26'h000, '0, '0, 7'h05);
    get_rsp(d, t, lat);
    check("t5_alias_data", d, 512'h1234);
    check("t5_alias_tag", t, 7'h05);
    wait_idle();

    // Test 6: reset while reads are in flight
    mif.mem_rsp_ready = 1'b0;
    send(1'b0, 26'h10, '0, '0, 7'h31);
    send(1'b0, 26'h20, '0, '0, 7'h32);
    send(1'b0, 26'h400, '0, '0, 7'h33);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", mif.mem_rsp_valid, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_ready", mif.mem_req_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = rsp_seen;
    mif.mem_rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_stale_rsp", 32'(rsp_seen), 32'(seen));
    send(1'b0, 26'h10, '0, '0, 7'h3F);
    get_rsp(d, t, lat);
    check("t6_retained_data", d, {16{32'hDEADBEEF}});
    check("t6_retained_tag", t, 7'h3F);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_mem_responder.md
Name: vx_mem_responder

Overview:
Synthesizable memory-side responder for the Vortex external memory request/response interface. It is the slave end of mem_req_*/mem_rsp_*: it accepts read and write requests from the core, holds a small byte-enabled backing store, and returns read data with the original tag after a fixed latency, in order. It is used in simulation benches and FPGA bring-up in place of a DRAM controller.

Parameters:
DATA_WIDTH, 512, line width in bits; byteen width is DATA_WIDTH/8
ADDR_WIDTH, 26, line address width
TAG_WIDTH, 7, request/response tag width
MEM_DEPTH_LOG2, 10, log2 of backing-store depth in lines
LATENCY, 4, accept-to-response delay in cycles (>=1)
RSP_QUEUE, 8, response FIFO depth and maximum outstanding reads (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
mem_req_valid  in  1  request valid
mem_req_rw  in  1  1=write, 0=read
mem_req_byteen  in  DATA_WIDTH/8  write byte enables
mem_req_addr  in  ADDR_WIDTH  line address
mem_req_data  in  DATA_WIDTH  write data
mem_req_tag  in  TAG_WIDTH  request tag
mem_req_ready  out  1  request accepted when valid&&ready
mem_rsp_valid  out  1  read response valid
mem_rsp_data  out  DATA_WIDTH  read data
mem_rsp_tag  out  TAG_WIDTH  tag of the originating read
mem_rsp_ready  in  1  response consumed when valid&&ready
busy  out  1  reads outstanding

Behaviour:
- Reset: asynchronous, active-high; clears pipeline valid bits, FIFO pointers and outstanding counter. While reset is high, mem_req_ready=0, mem_rsp_valid=0, mem_rsp_data=0, mem_rsp_tag=0, busy=0. Backing store is not reset; it is zero at time 0 and retains its contents across reset.
- Index: line = mem_req_addr[MEM_DEPTH_LOG2-1:0]. Upper address bits are ignored, so addresses alias modulo the depth.
- Write (fire && rw=1): byte i of the line is updated iff byteen[i]. The update is visible at the next edge. No response is generated, and the outstanding count is unchanged.
- Read (fire && rw=0): the line is read at the accepting edge. A write accepted on the previous cycle is visible to it. Data and tag enter a LATENCY-stage delay line, then the response FIFO.
- Timing: with the FIFO empty, a read accepted at edge E gives mem_rsp_valid=1 after edge E+LATENCY. Back-to-back reads give back-to-back responses.
- Ordering: responses are returned strictly in acceptance order.
- Outstanding counter: counts reads in the delay line plus reads in the FIFO.
  - +1 on an accepted read.
  - -1 on a response handshake.
  - Both in the same cycle: unchanged.
- mem_req_ready = !reset && (outstanding < RSP_QUEUE). It applies to reads and writes alike and is derived from registered state only, never from mem_req_valid. The FIFO therefore cannot overflow.
- Response hold: while mem_rsp_valid && !mem_rsp_ready, mem_rsp_data and mem_rsp_tag are held stable. mem_rsp_valid does not drop until the handshake completes.
- FIFO pointers wrap modulo RSP_QUEUE. Full/empty use an extra pointer bit.
- busy = (outstanding != 0).
- Reset mid-operation: in-flight and queued responses are discarded and never emitted after release.

Test Plan:
1. Release reset; write addr 0x0000010, byteen all ones, data {16{32'hDEADBEEF}}; next cycle read the same address, tag 0x15 -> mem_rsp_valid exactly 4 cycles after the read is accepted, data {16{32'hDEADBEEF}}, tag 0x15, busy high in between.
2. Write 0x0000020 with all-ones data, then write 0x0000020 with byteen 64'h1 and data 512'hAB; read it -> byte0=0xAB, bytes 1..63=0xFF.
3. Hold mem_rsp_ready=0; drive reads with tags 0..9 every cycle -> exactly 8 accepted and mem_req_ready low while outstanding=8. Then set mem_rsp_ready=1 -> tags 0..7 in order with stable data across stalls; ready returns and tags 8,9 follow.
4. Three writes to distinct addresses -> mem_rsp_valid never asserts, busy stays 0, ready stays 1.
5. Write 0x0000400 with data 512'h1234; read 0x0000000 -> returns 512'h1234 (aliasing at depth 1024).
6. Issue 3 reads, then assert reset 2 cycles later -> mem_rsp_valid and busy drop to 0 immediately without waiting for clk. After release, no responses appear within 10 cycles, and a read of a previously written line returns the retained data.
